tsn_queue_sched: RTL



---
 rtl/tsn_qsched_pkg.sv | 17 +
 rtl/qsched_rr_arb.sv | 36 +++
 rtl/tsn_queue_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tsn_qsched_pkg.sv
// Shared types and helpers for the TSN queue scheduler.
package tsn_qsched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 65;
  localparam int LAST_BIT  = DEF_WIDTH - 1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qsched_rr_arb.sv
// Masked round-robin pick: first eligible index at or after ptr_i, wrapping to the lowest
// eligible index when nothing at or above the pointer is eligible.
module qsched_rr_arb
  import tsn_qsched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int IDX_W = clog2_min1(NUM_Q)
) (
  input  logic [NUM_Q-1:0] elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [NUM_Q-1:0] masked;

  always_comb begin
    masked  = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      masked[i] = elig_i[i] & (IDX_W'(i) >= ptr_i);
    end
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
    // A hit in the masked upper range overrides the wrapped pick.
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (masked[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tsn_queue_sched.sv
// Frame-aware scheduler draining NUM_Q FWFT FIFOs onto one registered valid/ready stream.
// Define TSN_QSCHED_STRICT_PRIO_EN for strict priority (lowest eligible index wins) instead of round-robin.
module tsn_queue_sched
  import tsn_qsched_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = clog2_min1(NUM_Q)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_Q-1:0]       i_q_empty,
  input  logic [NUM_Q*WIDTH-1:0] i_q_dout,
  output logic [NUM_Q-1:0]       o_q_rd_en,
  input  logic [NUM_Q-1:0]       i_q_gate,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-2:0]       o_data,
  output logic                   o_last,
  output logic [IDX_W-1:0]       o_qid,
  output logic                   o_busy,
  output logic                   o_underrun
);

  // Handshake: a word transfers on a cycle where o_valid & i_ready; while o_valid & ~i_ready
  // the output register holds. The FIFO side pops only when the output register is free or draining.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic               valid_q, last_q, underrun_q;
  logic [WIDTH-2:0]   data_q;
  logic [IDX_W-1:0]   qid_q;
  logic [NUM_Q-1:0]   elig;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [WIDTH-1:0]   dout_arr [NUM_Q];
  logic [WIDTH-1:0]   head;
  logic               pop;

  assign elig = ~i_q_empty & i_q_gate;

  always_comb begin
    for (int k = 0; k < NUM_Q; k++) dout_arr[k] = i_q_dout[k*WIDTH +: WIDTH];
  end

  assign head = dout_arr[grant_q];
  assign pop  = (state_q == XFER) & ~i_q_empty[grant_q] & (~valid_q | i_ready);

  qsched_rr_arb #(.NUM_Q(NUM_Q), .IDX_W(IDX_W)) u_arb (
    .elig_i  (elig),
    .ptr_i   (rr_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef TSN_QSCHED_STRICT_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q <= '0;
    end else if (pop && head[WIDTH-1]) begin
      rr_q <= (grant_q == IDX_W'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign rr_ptr = rr_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = XFER;
      XFER:    if (pop && head[WIDTH-1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy             = (state_q == XFER);
    o_q_rd_en          = '0;
    o_q_rd_en[grant_q] = pop;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      qid_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_found) grant_q <= pick_idx;
      if (pop) begin
        valid_q <= 1'b1;
        data_q  <= head[WIDTH-2:0];
        last_q  <= head[WIDTH-1];
        qid_q   <= grant_q;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
      // The grant is held through an empty spell; the frame resumes when data returns.
      if (state_q == XFER && i_q_empty[grant_q]) underrun_q <= 1'b1;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_qid      = qid_q;
  assign o_underrun = underrun_q;

endmodule
